// File: rtl/fric_pkg.sv
// Shared types, protocol constants and helpers for the fric master-port arbiter.
package fric_pkg;

   localparam logic [3:0] FRIC_TYPE_WR  = 4'h2;
   localparam logic [3:0] FRIC_TYPE_RD  = 4'h3;
   localparam logic [3:0] FRIC_TYPE_ERR = 4'hF;

   localparam logic [2:0] WR_REQ_LEN = 3'd4;
   localparam logic [2:0] WR_REP_LEN = 3'd2;
   localparam logic [2:0] RD_REQ_LEN = 3'd2;
   localparam logic [2:0] RD_REP_LEN = 3'd4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_SEND  = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_REPLY = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_BODY = 2'd1,
      CAP_PEND = 2'd2
   } cap_state_t;

   function automatic logic is_req_type(input logic [3:0] t);
      return (t == FRIC_TYPE_WR) || (t == FRIC_TYPE_RD);
   endfunction

   function automatic logic [2:0] req_len(input logic [3:0] t);
      return (t == FRIC_TYPE_WR) ? WR_REQ_LEN : RD_REQ_LEN;
   endfunction

   function automatic logic [2:0] rep_len(input logic [3:0] t);
      return (t == FRIC_TYPE_WR) ? WR_REP_LEN : RD_REP_LEN;
   endfunction

   // First pending index at or after rr, wrapping 3 -> 0.
   function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] rr);
      logic [1:0] sel;
      logic [1:0] idx;
      logic       found;
      sel   = rr;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = rr + 2'(i);
         if (!found && pend[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/fric_req_capture.sv
// Per-requester input register, capture FSM and 4-word holding buffer.
// state    | meaning
// CAP_IDLE | waiting for a write/read word0 on the registered input
// CAP_BODY | storing the remaining request words on consecutive cycles
// CAP_PEND | request complete and pending; input ignored until done
module fric_req_capture
   import fric_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      fric_in,
   input  logic            done,
   output logic            pending,
   output logic [3:0][7:0] req_buf
);

   logic [7:0]      fric_inr;
   cap_state_t      state, state_n;
   logic [1:0]      cnt, cnt_n;
   logic [3:0][7:0] buf_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fric_inr <= 8'h00;
         state    <= CAP_IDLE;
         cnt      <= 2'd0;
         req_buf  <= '0;
      end else begin
         fric_inr <= fric_in;
         state    <= state_n;
         cnt      <= cnt_n;
         req_buf  <= buf_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      buf_n   = req_buf;
      case (state)
         CAP_IDLE: begin
            if (is_req_type(fric_inr[7:4])) begin
               buf_n[0] = fric_inr;
               cnt_n    = 2'd1;
               state_n  = CAP_BODY;
            end
         end
         CAP_BODY: begin
            buf_n[cnt] = fric_inr;
            if ({1'b0, cnt} == req_len(req_buf[0][7:4]) - 3'd1) state_n = CAP_PEND;
            else                                                 cnt_n   = cnt + 2'd1;
         end
         CAP_PEND: begin
            if (done) state_n = CAP_IDLE;
         end
         default: state_n = CAP_IDLE;
      endcase
   end

   assign pending = (state == CAP_PEND);

endmodule

// File: rtl/fric_master_arb_4port.sv
// Round-robin arbiter sharing the fric switch master port among 4 requesters.
// Optional ARB_WAIT watchdog with synthetic error reply: FRIC_ARB_TIMEOUT_EN.
// state     | meaning
// ARB_IDLE  | no transaction; grant next pending requester round-robin
// ARB_SEND  | replaying the granted request on sw_out, one word per cycle
// ARB_WAIT  | waiting for the first nonzero reply word from the switch
// ARB_REPLY | forwarding the reply to the granted requester, then release
module fric_master_arb_4port
   import fric_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] fric_in0,
   input  logic [7:0] fric_in1,
   input  logic [7:0] fric_in2,
   input  logic [7:0] fric_in3,
   output logic [7:0] fric_out0,
   output logic [7:0] fric_out1,
   output logic [7:0] fric_out2,
   output logic [7:0] fric_out3,
   output logic [7:0] sw_out,
   input  logic [7:0] sw_in,
   output logic [1:0] grant,
   output logic       busy,
   output logic       timeout_err
);

   logic [7:0]      fric_in_a [4];
   logic [3:0]      pending;
   logic [3:0]      done;
   logic [3:0][7:0] req_buf [4];

   assign fric_in_a[0] = fric_in0;
   assign fric_in_a[1] = fric_in1;
   assign fric_in_a[2] = fric_in2;
   assign fric_in_a[3] = fric_in3;

   for (genvar g = 0; g < 4; g++) begin : g_cap
      fric_req_capture u_cap (
         .clk     (clk),
         .rst_n   (rst_n),
         .fric_in (fric_in_a[g]),
         .done    (done[g]),
         .pending (pending[g]),
         .req_buf (req_buf[g])
      );
   end

   arb_state_t state, state_n;
   logic [1:0] grant_n, idx, idx_n, rr, rr_n;
   logic [2:0] rcnt, rcnt_n;
   logic       timed_out, timed_out_n;
   logic [7:0] fout_q [4];
   logic [7:0] fout_n [4];
   logic [7:0] w0_g;
   logic       wd_fire;

   assign w0_g   = req_buf[grant][0];
   assign sw_out = (state == ARB_SEND) ? req_buf[grant][idx] : 8'h00;
   assign busy   = (state != ARB_IDLE);

`ifdef FRIC_ARB_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0] wd_cnt;

   // Reloads outside ARB_WAIT, so it expires on the TIMEOUT_CYCLES-th waiting cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt      <= WD_W'(TIMEOUT_CYCLES - 1);
         timeout_err <= 1'b0;
      end else begin
         if (state != ARB_WAIT)   wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
         else if (wd_cnt != '0)   wd_cnt <= wd_cnt - WD_W'(1);
         if (wd_fire)             timeout_err <= 1'b1;
      end
   end

   assign wd_fire = (state == ARB_WAIT) && (wd_cnt == '0) && (sw_in[7:4] == 4'h0);
`else
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         grant     <= 2'd0;
         idx       <= 2'd0;
         rcnt      <= 3'd0;
         rr        <= 2'd0;
         timed_out <= 1'b0;
         fout_q    <= '{default: 8'h00};
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         idx       <= idx_n;
         rcnt      <= rcnt_n;
         rr        <= rr_n;
         timed_out <= timed_out_n;
         fout_q    <= fout_n;
      end
   end

   always_comb begin
      state_n     = state;
      grant_n     = grant;
      idx_n       = idx;
      rcnt_n      = rcnt;
      rr_n        = rr;
      timed_out_n = timed_out;
      done        = 4'b0000;
      for (int i = 0; i < 4; i++) fout_n[i] = 8'h00;
      case (state)
         ARB_IDLE: begin
            if (|pending) begin
               grant_n = rr_pick(pending, rr);
               idx_n   = 2'd0;
               state_n = ARB_SEND;
            end
         end
         ARB_SEND: begin
            if ({1'b0, idx} == req_len(w0_g[7:4]) - 3'd1) state_n = ARB_WAIT;
            else                                          idx_n   = idx + 2'd1;
         end
         ARB_WAIT: begin
            if (sw_in[7:4] != 4'h0) begin
               fout_n[grant] = sw_in;
               rcnt_n        = 3'd1;
               timed_out_n   = 1'b0;
               state_n       = ARB_REPLY;
            end else if (wd_fire) begin
               fout_n[grant] = {FRIC_TYPE_ERR, w0_g[3:0]};
               rcnt_n        = 3'd1;
               timed_out_n   = 1'b1;
               state_n       = ARB_REPLY;
            end
         end
         ARB_REPLY: begin
            // Last reply word is on fric_out this cycle; release the requester.
            if (rcnt == rep_len(w0_g[7:4])) begin
               done[grant] = 1'b1;
               rr_n        = grant + 2'd1;
               state_n     = ARB_IDLE;
            end else begin
               fout_n[grant] = timed_out ? 8'h00 : sw_in;
               rcnt_n        = rcnt + 3'd1;
            end
         end
         default: state_n = ARB_IDLE;
      endcase
   end

   assign fric_out0 = fout_q[0];
   assign fric_out1 = fout_q[1];
   assign fric_out2 = fout_q[2];
   assign fric_out3 = fout_q[3];

endmodule

// File: tb/tb_fric_master_arb_4port.sv
// Scoreboard bench for fric_master_arb_4port; exercises the watchdog when FRIC_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_fric_master_arb_4port;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] fin  [4];
   logic [7:0] fout [4];
   logic [7:0] sw_out, sw_in;
   logic [1:0] grant;
   logic       busy, timeout_err;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_sw [$];
   logic [1:0] exp_gr [$];
   logic [7:0] exp_out [4][$];
   bit         mon_en   = 1'b1;
   bit         sw_mute  = 1'b0;
   int         sw_delay = 0;

   always #5 clk = ~clk;

   fric_master_arb_4port #(.TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fric_in0    (fin[0]),
      .fric_in1    (fin[1]),
      .fric_in2    (fin[2]),
      .fric_in3    (fin[3]),
      .fric_out0   (fout[0]),
      .fric_out1   (fout[1]),
      .fric_out2   (fout[2]),
      .fric_out3   (fout[3]),
      .sw_out      (sw_out),
      .sw_in       (sw_in),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit queues_empty();
      return (exp_sw.size() == 0) && (exp_out[0].size() == 0) && (exp_out[1].size() == 0) &&
             (exp_out[2].size() == 0) && (exp_out[3].size() == 0);
   endfunction

   task automatic push_rd(input int n, input logic [7:0] w0, addr, r0, r1);
      exp_sw.push_back(w0);  exp_sw.push_back(addr);
      exp_gr.push_back(2'(n));
      exp_out[n].push_back(w0); exp_out[n].push_back(addr);
      exp_out[n].push_back(r0); exp_out[n].push_back(r1);
   endtask

   task automatic push_wr(input int n, input logic [7:0] w0, addr, d0, d1);
      exp_sw.push_back(w0); exp_sw.push_back(addr);
      exp_sw.push_back(d0); exp_sw.push_back(d1);
      exp_gr.push_back(2'(n));
      exp_out[n].push_back(w0); exp_out[n].push_back(addr);
   endtask

   // Caller is aligned 1 ns after a rising edge.
   task automatic drive(input int n, input logic [7:0] w0, w1, w2, w3, input int len);
      logic [7:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < len; i++) begin
         fin[n] = w[i];
         @(posedge clk); #1;
      end
      fin[n] = 8'h00;
   endtask

   task automatic wait_done(input string name, input int budget);
      int c;
      c = 0;
      while (!(queues_empty() && !busy) && c < budget) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (c >= budget) begin
         errors++;
         $display("FAIL %s: still busy=%0b after %0d cycles, expected idle", name, busy, c);
      end
      @(posedge clk); #1;
   endtask

   // Switch model: echoes w0/addr; read data are addr+1, addr+2.
   initial begin
      logic [7:0] rq [4];
      logic [7:0] rp [$];
      int rq_cnt, rq_len, wait_c;
      sw_in = 8'h00; rq_cnt = 0; rq_len = 0; wait_c = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rq_cnt = 0; wait_c = 0; rp.delete(); sw_in = 8'h00;
         end else begin
            if (wait_c > 0)          begin wait_c--; sw_in = 8'h00; end
            else if (rp.size() > 0)  sw_in = rp.pop_front();
            else                     sw_in = 8'h00;
            if (rq_cnt > 0 || sw_out != 8'h00) begin
               if (rq_cnt == 0) rq_len = (sw_out[7:4] == 4'h2) ? 4 : 2;
               rq[rq_cnt] = sw_out;
               rq_cnt++;
               if (rq_cnt == rq_len) begin
                  rq_cnt = 0;
                  if (!sw_mute) begin
                     wait_c = sw_delay;
                     rp.push_back(rq[0]); rp.push_back(rq[1]);
                     if (rq_len == 2) begin
                        rp.push_back(rq[1] + 8'd1); rp.push_back(rq[1] + 8'd2);
                     end
                  end
               end
            end
         end
      end
   end

   // Monitor: pops and compares whenever the DUT presents a word.
   initial begin
      int sw_left;
      int out_left [4];
      logic [7:0] e;
      sw_left = 0;
      for (int i = 0; i < 4; i++) out_left[i] = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !mon_en) begin
            sw_left = 0;
            for (int i = 0; i < 4; i++) out_left[i] = 0;
         end else begin
            if (sw_left > 0 || sw_out != 8'h00) begin
               if (exp_sw.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL sw_unexpected: got %h expected none", sw_out);
               end else begin
                  e = exp_sw.pop_front();
                  check("sw_out", sw_out, e);
                  if (sw_left == 0) begin
                     sw_left = (e[7:4] == 4'h2) ? 3 : 1;
                     if (exp_gr.size() > 0) check("grant", {6'b0, grant}, {6'b0, exp_gr.pop_front()});
                  end else sw_left--;
               end
            end
            for (int n = 0; n < 4; n++) begin
               if (out_left[n] > 0 || fout[n] != 8'h00) begin
                  if (exp_out[n].size() == 0) begin
                     checks++; errors++;
                     $display("FAIL out%0d_unexpected: got %h expected none", n, fout[n]);
                  end else begin
                     e = exp_out[n].pop_front();
                     check($sformatf("fric_out%0d", n), fout[n], e);
                     if (out_left[n] == 0) out_left[n] = (e[7:4] == 4'h2) ? 1 : 3;
                     else                  out_left[n]--;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      int c;
      for (int i = 0; i < 4; i++) fin[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sw_out", sw_out, 8'h00);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_grant", {6'b0, grant}, 8'h00);
      for (int n = 0; n < 4; n++) check($sformatf("rst_out%0d", n), fout[n], 8'h00);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Three reads completing together: order 0, 2, 3.
      push_rd(0, 8'h31, 8'h40, 8'h41, 8'h42);
      push_rd(2, 8'h32, 8'h50, 8'h51, 8'h52);
      push_rd(3, 8'h35, 8'h60, 8'h61, 8'h62);
      fork
         drive(0, 8'h31, 8'h40, 8'h00, 8'h00, 2);
         drive(2, 8'h32, 8'h50, 8'h00, 8'h00, 2);
         drive(3, 8'h35, 8'h60, 8'h00, 8'h00, 2);
      join
      wait_done("three_reads", 100);

      // Single write on requester 1, ack one cycle after the switch.
      push_wr(1, 8'h23, 8'h10, 8'hAA, 8'h55);
      drive(1, 8'h23, 8'h10, 8'hAA, 8'h55, 4);
      c = 0;
      while (sw_in != 8'h23 && c < 40) begin @(posedge clk); c++; end
      @(negedge clk);
      check("ack_latency", fout[1], 8'h23);
      wait_done("write_1", 60);

      // Illegal word dropped.
      drive(0, 8'h51, 8'h00, 8'h00, 8'h00, 1);
      repeat (5) @(negedge clk);
      check("illegal_busy", {7'b0, busy}, 8'h00);
      check("illegal_sw_out", sw_out, 8'h00);
      @(posedge clk); #1;
      push_rd(0, 8'h31, 8'h44, 8'h45, 8'h46);
      drive(0, 8'h51, 8'h31, 8'h44, 8'h00, 3);
      wait_done("after_illegal", 60);

      // Requester 1 completes while 0 waits; then 2 beats 0.
      sw_delay = 8;
      push_rd(0, 8'h31, 8'h40, 8'h41, 8'h42);
      push_wr(1, 8'h24, 8'h20, 8'h01, 8'h02);
      push_rd(2, 8'h33, 8'h70, 8'h71, 8'h72);
      push_rd(0, 8'h36, 8'h80, 8'h81, 8'h82);
      fork
         drive(0, 8'h31, 8'h40, 8'h00, 8'h00, 2);
         begin
            repeat (3) @(posedge clk); #1;
            drive(1, 8'h24, 8'h20, 8'h01, 8'h02, 4);
         end
      join
      c = 0;
      while (fout[0] != 8'h42 && c < 60) begin @(negedge clk); c++; end
      @(negedge clk);
      check("rel_busy", {7'b0, busy}, 8'h00);
      check("rel_out0", fout[0], 8'h00);
      @(negedge clk);
      check("next_grant", {6'b0, grant}, 8'h01);
      check("next_sw_out", sw_out, 8'h24);
      @(posedge clk); #1;
      fork
         drive(2, 8'h33, 8'h70, 8'h00, 8'h00, 2);
         drive(0, 8'h36, 8'h80, 8'h00, 8'h00, 2);
      join
      wait_done("rr_sequence", 200);
      sw_delay = 0;

      // Reset in ARB_SEND.
      mon_en = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      drive(2, 8'h22, 8'h30, 8'h11, 8'h22, 4);
      c = 0;
      while (sw_out != 8'h30 && c < 20) begin @(negedge clk); c++; end
      check("pre_reset_sw_out", sw_out, 8'h30);
      rst_n = 1'b0;
      #1;
      check("reset_sw_out", sw_out, 8'h00);
      check("reset_busy", {7'b0, busy}, 8'h00);
      check("reset_grant", {6'b0, grant}, 8'h00);
      check("reset_timeout_err", {7'b0, timeout_err}, 8'h00);
      for (int n = 0; n < 4; n++) check($sformatf("reset_out%0d", n), fout[n], 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_reset_sw_out", sw_out, 8'h00);
         check("post_reset_busy", {7'b0, busy}, 8'h00);
      end
      mon_en = 1'b1;
      @(posedge clk); #1;
      push_rd(3, 8'h31, 8'h90, 8'h91, 8'h92);
      drive(3, 8'h31, 8'h90, 8'h00, 8'h00, 2);
      wait_done("after_reset", 60);

`ifdef FRIC_ARB_TIMEOUT_EN
      sw_mute = 1'b1;
      exp_sw.push_back(8'h34); exp_sw.push_back(8'h07);
      exp_gr.push_back(2'd0);
      exp_out[0].push_back(8'hF4); exp_out[0].push_back(8'h00);
      exp_out[0].push_back(8'h00); exp_out[0].push_back(8'h00);
      drive(0, 8'h34, 8'h07, 8'h00, 8'h00, 2);
      wait_done("timeout_reply", 80);
      check("timeout_err", {7'b0, timeout_err}, 8'h01);
      sw_mute = 1'b0;
`else
      check("timeout_err_tied", {7'b0, timeout_err}, 8'h00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
